// File: rtl/fp_add_sched_if.sv
// rtl/fp_add_sched_if.sv - requester, shared-adder and response bundle for fp_add_sched
interface fp_add_sched_if #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned FP_WIDTH = 32
);

  // requester side: one operation slot per requester
  logic [NUM_REQ-1:0]                req_valid_i;
  logic [NUM_REQ-1:0]                req_ready_o;
  logic [NUM_REQ-1:0][FP_WIDTH-1:0]  req_a_i;
  logic [NUM_REQ-1:0][FP_WIDTH-1:0]  req_b_i;
  logic [NUM_REQ-1:0]                req_sub_i;
  logic [NUM_REQ-1:0][2:0]           req_rnd_i;

  // shared add + round unit
  logic [FP_WIDTH-1:0]               add_a_o;
  logic [FP_WIDTH-1:0]               add_b_o;
  logic                              add_sub_o;
  logic [2:0]                        add_rnd_o;
  logic                              add_start_o;
  logic                              add_done_i;
  logic [FP_WIDTH-1:0]               add_res_i;
  logic [4:0]                        add_flags_i;

  // response side: result/flags shared, valid per requester
  logic [NUM_REQ-1:0]                rsp_valid_o;
  logic [NUM_REQ-1:0]                rsp_ready_i;
  logic [FP_WIDTH-1:0]               rsp_res_o;
  logic [4:0]                        rsp_flags_o;

  // status
  logic                              busy_o;
  logic [31:0]                       op_cnt_o;

  // scheduler view
  modport slave (
    input  req_valid_i, req_a_i, req_b_i, req_sub_i, req_rnd_i,
    output req_ready_o,
    output add_a_o, add_b_o, add_sub_o, add_rnd_o, add_start_o,
    input  add_done_i, add_res_i, add_flags_i,
    output rsp_valid_o, rsp_res_o, rsp_flags_o,
    input  rsp_ready_i,
    output busy_o, op_cnt_o
  );

  // environment view: requesters plus the shared unit
  modport master (
    output req_valid_i, req_a_i, req_b_i, req_sub_i, req_rnd_i,
    input  req_ready_o,
    input  add_a_o, add_b_o, add_sub_o, add_rnd_o, add_start_o,
    output add_done_i, add_res_i, add_flags_i,
    input  rsp_valid_o, rsp_res_o, rsp_flags_o,
    output rsp_ready_i,
    input  busy_o, op_cnt_o
  );

endinterface

// File: rtl/fp_add_sched.sv
// rtl/fp_add_sched.sv - round-robin scheduler sharing one fp add/round unit among requesters
module fp_add_sched #(
  parameter int unsigned NUM_REQ   = 4,
  // format encoding: 0 = FP32, 1 = FP64, 2 = FP16, 3 = FP16ALT (bfloat16)
  parameter logic [1:0]  FP_FORMAT = 2'd0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  fp_add_sched_if.slave bus
);

  function automatic int unsigned fp_width(input logic [1:0] fmt);
    case (fmt)
      2'd0:    return 32;
      2'd1:    return 64;
      2'd2:    return 16;
      default: return 16;
    endcase
  endfunction

  localparam int unsigned FP_WIDTH = fp_width(FP_FORMAT);
  localparam int unsigned IDX_W    = $clog2(NUM_REQ);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [1:0]          state_q;
  logic [IDX_W-1:0]    gnt_q;
  logic [IDX_W-1:0]    ptr_q;
  logic [FP_WIDTH-1:0] a_q;
  logic [FP_WIDTH-1:0] b_q;
  logic                sub_q;
  logic [2:0]          rnd_q;
  logic [FP_WIDTH-1:0] res_q;
  logic [4:0]          flags_q;
  logic [31:0]         cnt_q;

  logic                arb_found;
  logic [IDX_W-1:0]    arb_idx;
  logic [NUM_REQ-1:0]  arb_onehot;
  logic [NUM_REQ-1:0]  gnt_onehot;
  logic                rsp_take;
  logic                unit_done;

  // rotating priority search: first valid requester at or after ptr, wrapping to 0
  always_comb begin
    int unsigned cand;
    cand      = 0;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (32'(ptr_q) + i) % NUM_REQ;
      if (!arb_found && bus.req_valid_i[IDX_W'(cand)]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(cand);
      end
    end
  end

  assign arb_onehot = NUM_REQ'(1) << arb_idx;
  assign gnt_onehot = NUM_REQ'(1) << gnt_q;

  // done only matters while an op is actually outstanding at the unit
  assign unit_done = bus.add_done_i && (state_q == ISSUE || state_q == WAIT);
  // only the granted requester can retire the response
  assign rsp_take  = (state_q == RESP) && bus.rsp_ready_i[gnt_q];

  // accept handshake exists only in IDLE, and only toward the winner
  assign bus.req_ready_o = (state_q == IDLE && arb_found) ? arb_onehot : '0;

  assign bus.add_a_o     = a_q;
  assign bus.add_b_o     = b_q;
  assign bus.add_sub_o   = sub_q;
  assign bus.add_rnd_o   = rnd_q;
  assign bus.add_start_o = (state_q == ISSUE);

  assign bus.rsp_valid_o = (state_q == RESP) ? gnt_onehot : '0;
  assign bus.rsp_res_o   = res_q;
  assign bus.rsp_flags_o = flags_q;

  assign bus.busy_o      = (state_q != IDLE);
  assign bus.op_cnt_o    = cnt_q;

  // state machine, operand/result latches, rotation pointer and completion counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      rnd_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_found) begin
            gnt_q   <= arb_idx;
            a_q     <= bus.req_a_i[arb_idx];
            b_q     <= bus.req_b_i[arb_idx];
            sub_q   <= bus.req_sub_i[arb_idx];
            rnd_q   <= bus.req_rnd_i[arb_idx];
            state_q <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          // a combinational unit answers during ISSUE, skipping WAIT entirely
          if (unit_done) begin
            res_q   <= bus.add_res_i;
            flags_q <= bus.add_flags_i;
            state_q <= RESP;
          end else begin
            state_q <= WAIT;
          end
        end
        RESP: begin
          if (rsp_take) begin
            ptr_q   <= (gnt_q == LAST_IDX) ? '0 : gnt_q + IDX_W'(1);
            cnt_q   <= cnt_q + 32'd1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_sched.sv
// tb/tb_fp_add_sched.sv - directed self-checking bench for fp_add_sched
module tb_fp_add_sched;

  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned FP_WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic comb_mode;
  logic done_drv;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fp_add_sched_if #(.NUM_REQ(NUM_REQ), .FP_WIDTH(FP_WIDTH)) bus ();

  fp_add_sched #(.NUM_REQ(NUM_REQ), .FP_FORMAT(2'd0)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // unit model: either answers in the start cycle, or when the bench raises done_drv
  assign bus.add_done_i = (comb_mode && bus.add_start_o) || done_drv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n           = 1'b0;
    comb_mode       = 1'b0;
    done_drv        = 1'b0;
    bus.req_valid_i = '0;
    bus.req_a_i     = '0;
    bus.req_b_i     = '0;
    bus.req_sub_i   = '0;
    bus.req_rnd_i   = '0;
    bus.rsp_ready_i = '0;
    bus.add_res_i   = '0;
    bus.add_flags_i = '0;

    // reset state
    tick();
    tick();
    check("rst_busy",   32'(bus.busy_o),      32'd0);
    check("rst_start",  32'(bus.add_start_o), 32'd0);
    check("rst_rspv",   32'(bus.rsp_valid_o), 32'd0);
    check("rst_ready",  32'(bus.req_ready_o), 32'd0);
    check("rst_cnt",    bus.op_cnt_o,         32'd0);
    check("rst_add_a",  bus.add_a_o,          32'd0);
    rst_n = 1'b1;

    // single op, combinational unit: 1.0 + 2.0 = 3.0
    comb_mode       = 1'b1;
    bus.add_res_i   = 32'h4040_0000;
    bus.add_flags_i = 5'd0;
    bus.req_a_i[1]  = 32'h3F80_0000;
    bus.req_b_i[1]  = 32'h4000_0000;
    bus.req_valid_i = 4'b0010;
    settle();
    check("t1_ready_c0", 32'(bus.req_ready_o), 32'h2);
    check("t1_busy_c0",  32'(bus.busy_o),      32'd0);
    tick();
    bus.req_valid_i = '0;
    settle();
    check("t1_start_c1", 32'(bus.add_start_o), 32'd1);
    check("t1_add_a",    bus.add_a_o,          32'h3F80_0000);
    check("t1_add_b",    bus.add_b_o,          32'h4000_0000);
    check("t1_add_sub",  32'(bus.add_sub_o),   32'd0);
    check("t1_ready_c1", 32'(bus.req_ready_o), 32'd0);
    check("t1_rspv_c1",  32'(bus.rsp_valid_o), 32'd0);
    tick();
    settle();
    check("t1_start_c2", 32'(bus.add_start_o), 32'd0);
    check("t1_rspv_c2",  32'(bus.rsp_valid_o), 32'h2);
    check("t1_res",      bus.rsp_res_o,        32'h4040_0000);
    check("t1_flags",    32'(bus.rsp_flags_o), 32'd0);
    bus.rsp_ready_i = 4'b0010;
    tick();
    bus.rsp_ready_i = '0;
    settle();
    check("t1_cnt",      bus.op_cnt_o,         32'd1);
    check("t1_idle",     32'(bus.busy_o),      32'd0);

    // round robin with everyone valid, ptr restarted at 0
    do_reset();
    check("t2_cnt_rst", bus.op_cnt_o, 32'd0);
    comb_mode = 1'b1;
    for (int i = 0; i < 4; i++) bus.req_a_i[i] = 32'h1000_0000 + 32'(i);
    bus.req_valid_i = 4'hF;
    bus.rsp_ready_i = 4'hF;
    for (int k = 0; k < 5; k++) begin
      settle();
      check("t2_grant", 32'(bus.req_ready_o), 32'd1 << (k % 4));
      tick();
      check("t2_issue_a", bus.add_a_o, 32'h1000_0000 + 32'(k % 4));
      check("t2_no_rsp",  32'(bus.rsp_valid_o), 32'd0);
      tick();
      check("t2_rspv",    32'(bus.rsp_valid_o), 32'd1 << (k % 4));
      tick();
    end
    bus.req_valid_i = '0;
    bus.rsp_ready_i = '0;
    settle();
    check("t2_cnt", bus.op_cnt_o, 32'd5);

    // five-cycle unit latency on requester 3 (ptr now 1)
    comb_mode       = 1'b0;
    bus.req_a_i[3]  = 32'h40A0_0000;
    bus.req_b_i[3]  = 32'h3F00_0000;
    bus.req_sub_i   = 4'b1000;
    bus.req_rnd_i[3] = 3'd1;
    bus.req_valid_i = 4'b1000;
    settle();
    check("t3_ready", 32'(bus.req_ready_o), 32'h8);
    tick();
    bus.req_valid_i = '0;
    settle();
    check("t3_start", 32'(bus.add_start_o), 32'd1);
    check("t3_sub",   32'(bus.add_sub_o),   32'd1);
    check("t3_rnd",   32'(bus.add_rnd_o),   32'd1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("t3_wait_start", 32'(bus.add_start_o), 32'd0);
      check("t3_wait_a",     bus.add_a_o,          32'h40A0_0000);
      check("t3_wait_b",     bus.add_b_o,          32'h3F00_0000);
      check("t3_wait_rspv",  32'(bus.rsp_valid_o), 32'd0);
    end
    tick();
    bus.add_res_i   = 32'h4090_0000;
    bus.add_flags_i = 5'b00001;
    done_drv        = 1'b1;
    settle();
    check("t3_rspv_done", 32'(bus.rsp_valid_o), 32'd0);
    tick();
    done_drv = 1'b0;
    settle();
    check("t3_rspv",  32'(bus.rsp_valid_o), 32'h8);
    check("t3_res",   bus.rsp_res_o,        32'h4090_0000);
    check("t3_flags", 32'(bus.rsp_flags_o), 32'h1);
    bus.rsp_ready_i = 4'b1000;
    tick();
    bus.rsp_ready_i = '0;
    bus.req_sub_i   = '0;
    check("t3_cnt", bus.op_cnt_o, 32'd6);

    // response backpressure on requester 2 while requester 0 waits (ptr now 0)
    comb_mode       = 1'b1;
    bus.add_res_i   = 32'h4120_0000;
    bus.add_flags_i = 5'd0;
    bus.req_a_i[2]  = 32'h4100_0000;
    bus.req_valid_i = 4'b0100;
    settle();
    check("t4_ready", 32'(bus.req_ready_o), 32'h4);
    tick();
    bus.req_valid_i = 4'b0101;
    bus.rsp_ready_i = 4'b0001;
    tick();
    for (int i = 0; i < 10; i++) begin
      check("t4_hold_rspv",  32'(bus.rsp_valid_o), 32'h4);
      check("t4_hold_res",   bus.rsp_res_o,        32'h4120_0000);
      check("t4_hold_ready", 32'(bus.req_ready_o), 32'd0);
      check("t4_hold_busy",  32'(bus.busy_o),      32'd1);
      tick();
    end
    bus.rsp_ready_i = 4'b0100;
    tick();
    check("t4_cnt",        bus.op_cnt_o,         32'd7);
    check("t4_next_grant", 32'(bus.req_ready_o), 32'h1);
    bus.req_valid_i = '0;
    bus.rsp_ready_i = '0;
    settle();

    // spurious done in IDLE, operand change after accept, spurious done in RESP (ptr 3)
    bus.add_res_i = 32'hBAD0_BAD0;
    done_drv      = 1'b1;
    tick();
    tick();
    check("t5_idle_busy", 32'(bus.busy_o),      32'd0);
    check("t5_idle_rspv", 32'(bus.rsp_valid_o), 32'd0);
    check("t5_idle_res",  bus.rsp_res_o,        32'h4120_0000);
    check("t5_idle_cnt",  bus.op_cnt_o,         32'd7);
    done_drv        = 1'b0;
    comb_mode       = 1'b0;
    bus.req_a_i[1]  = 32'h3F80_0000;
    bus.req_b_i[1]  = 32'h3F80_0000;
    bus.req_sub_i   = 4'b0010;
    bus.req_valid_i = 4'b0010;
    settle();
    check("t5_ready", 32'(bus.req_ready_o), 32'h2);
    tick();
    bus.req_valid_i = '0;
    bus.req_a_i[1]  = 32'hDEAD_BEEF;
    bus.req_b_i[1]  = 32'h0;
    settle();
    check("t5_latched_a", bus.add_a_o,        32'h3F80_0000);
    check("t5_latched_b", bus.add_b_o,        32'h3F80_0000);
    tick();
    check("t5_wait_a",    bus.add_a_o,        32'h3F80_0000);
    bus.add_res_i   = 32'h0;
    bus.add_flags_i = 5'd0;
    done_drv        = 1'b1;
    tick();
    done_drv = 1'b0;
    settle();
    check("t5_rspv", 32'(bus.rsp_valid_o), 32'h2);
    check("t5_res",  bus.rsp_res_o,        32'h0);
    bus.add_res_i   = 32'hBAD0_BAD0;
    bus.add_flags_i = 5'h1F;
    done_drv        = 1'b1;
    tick();
    tick();
    check("t5_resp_rspv",  32'(bus.rsp_valid_o), 32'h2);
    check("t5_resp_res",   bus.rsp_res_o,        32'h0);
    check("t5_resp_flags", 32'(bus.rsp_flags_o), 32'd0);
    done_drv        = 1'b0;
    bus.rsp_ready_i = 4'b0010;
    tick();
    bus.rsp_ready_i = '0;
    bus.req_sub_i   = '0;
    check("t5_cnt",  bus.op_cnt_o,    32'd8);
    check("t5_idle", 32'(bus.busy_o), 32'd0);

    // reset while WAITing on requester 3 (ptr 2)
    comb_mode       = 1'b0;
    bus.req_a_i[3]  = 32'h4000_0000;
    bus.req_valid_i = 4'b1000;
    tick();
    bus.req_valid_i = '0;
    tick();
    check("t6_busy_wait", 32'(bus.busy_o), 32'd1);
    rst_n = 1'b0;
    settle();
    check("t6_rst_busy",  32'(bus.busy_o),      32'd0);
    check("t6_rst_add_a", bus.add_a_o,          32'd0);
    check("t6_rst_start", 32'(bus.add_start_o), 32'd0);
    check("t6_rst_rspv",  32'(bus.rsp_valid_o), 32'd0);
    check("t6_rst_cnt",   bus.op_cnt_o,         32'd0);
    check("t6_rst_res",   bus.rsp_res_o,        32'd0);
    tick();
    rst_n           = 1'b1;
    bus.req_valid_i = 4'b1010;
    settle();
    check("t6_grant_from_0", 32'(bus.req_ready_o), 32'h2);
    bus.req_valid_i = '0;
    settle();
    tick();
    tick();
    check("t6_no_rsp",  32'(bus.rsp_valid_o), 32'd0);
    check("t6_idle",    32'(bus.busy_o),      32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
